// File: rtl/i2c_slot_tx_arbiter.sv
// i2c_slot_tx_arbiter
// Transmit scheduler that shares one serial line between two byte requesters.
// The line carries 11-bit frames (start 0, 8 data bits LSB-first, parity, stop 1).
// Frames start only on fixed 11-cycle slot boundaries that are aligned to reset,
// so a free-running receiver on the same clock and reset stays locked.
// Outputs are registered on the rising edge, so falling-edge samplers see stable data.
//
// Optional build macro PARITY_ODD_EN: when defined, the parity bit is the
// inverted XOR of the data (odd parity). Otherwise it is the plain XOR (even parity).
//
// Handshake: REQx acts as "valid" and GNTx as a one-cycle "ready/accept" pulse.
// DATAx is captured on the edge that raises GNTx. REQx/DATAx must be held
// stable until that edge, and may change from the following cycle onward.
// REQx is sampled only at slot boundaries (SLOT_POS 10 -> 0). A request that
// rises mid-slot waits for the next boundary.
// SLOT_TYPE exposes the current slot state (idle, frame, holdoff) for debug.

module i2c_slot_tx_arbiter #(
    parameter int unsigned IDLE_SLOTS = 0
) (
    input  logic       SYNCED_CLK,
    input  logic       RST,
    input  logic       REQ0,
    input  logic [7:0] DATA0,
    output logic       GNT0,
    input  logic       REQ1,
    input  logic [7:0] DATA1,
    output logic       GNT1,
    output logic       SDATA,
    output logic       BUSY,
    output logic       OWNER,
    output logic [3:0] SLOT_POS,
    output logic [1:0] SLOT_TYPE
);

    // Slot kinds. HOLDOFF behaves like IDLE on the line but uses up the
    // mandatory gap after a frame.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FRAME   = 2'd1,
        ST_HOLDOFF = 2'd2
    } slot_t;

    localparam logic [3:0] LAST_POS  = 4'd10;
    localparam logic [3:0] HOLD_LOAD = 4'(IDLE_SLOTS);

    slot_t      state;
    logic       prio;        // requester that wins the next tie
    logic [3:0] holdoff;     // remaining mandatory idle slots
    logic [7:0] shreg;       // data bits still to send, LSB next
    logic       par_bit;     // parity of the captured byte

    logic       any_req;
    logic       win_sel;
    logic [7:0] win_data;

    // Parity for the captured byte. The build macro selects odd or even parity.
    function automatic logic frame_parity(input logic [7:0] d);
`ifdef PARITY_ODD_EN
        return ~(^d);
`else
        return ^d;
`endif
    endfunction

    // Round-robin pick among the current requests; only used at a slot boundary.
    always_comb begin
        any_req  = REQ0 | REQ1;
        win_sel  = 1'b0;
        if (REQ0 && REQ1) begin
            win_sel = prio;
        end else if (REQ1) begin
            win_sel = 1'b1;
        end
        win_data = win_sel ? DATA1 : DATA0;
    end

    // Slot counter, slot state machine and registered line outputs.
    always_ff @(posedge SYNCED_CLK) begin
        if (!RST) begin
            SLOT_POS <= 4'd0;
            state    <= ST_IDLE;
            SDATA    <= 1'b1;
            BUSY     <= 1'b0;
            OWNER    <= 1'b0;
            GNT0     <= 1'b0;
            GNT1     <= 1'b0;
            prio     <= 1'b0;
            holdoff  <= 4'd0;
            shreg    <= 8'd0;
            par_bit  <= 1'b0;
        end else begin
            GNT0 <= 1'b0;
            GNT1 <= 1'b0;
            if (SLOT_POS == LAST_POS) begin
                // Slot boundary: choose what the next slot carries.
                SLOT_POS <= 4'd0;
                if (holdoff != 4'd0) begin
                    state   <= ST_HOLDOFF;
                    holdoff <= holdoff - 4'd1;
                    BUSY    <= 1'b0;
                    SDATA   <= 1'b1;
                end else if (!any_req) begin
                    state <= ST_IDLE;
                    BUSY  <= 1'b0;
                    SDATA <= 1'b1;
                end else begin
                    // Grant: the start bit goes out on this same edge.
                    state   <= ST_FRAME;
                    GNT0    <= ~win_sel;
                    GNT1    <= win_sel;
                    shreg   <= win_data;
                    par_bit <= frame_parity(win_data);
                    OWNER   <= win_sel;
                    BUSY    <= 1'b1;
                    SDATA   <= 1'b0;
                    prio    <= ~win_sel;
                    holdoff <= HOLD_LOAD;
                end
            end else begin
                SLOT_POS <= SLOT_POS + 4'd1;
                if (state == ST_FRAME) begin
                    if (SLOT_POS <= 4'd7) begin
                        // Entering positions 1..8: next data bit, LSB first.
                        SDATA <= shreg[0];
                        shreg <= {1'b0, shreg[7:1]};
                    end else if (SLOT_POS == 4'd8) begin
                        SDATA <= par_bit;
                    end else begin
                        SDATA <= 1'b1;
                    end
                end else begin
                    SDATA <= 1'b1;
                end
            end
        end
    end

    assign SLOT_TYPE = state;

endmodule

// File: doc/i2c_slot_tx_arbiter.md
# i2c_slot_tx_arbiter

Transmit-side scheduler for the team's 11-bit serial frame link (start 0, 8 data bits LSB-first, parity, stop 1). It shares one serial output line between two byte requesters using round-robin arbitration. It emits frames only on fixed 11-cycle slot boundaries aligned to reset, so the existing free-running frame receiver on the same clock and reset stays in lock. Output changes on the rising edge, so the receiver's falling-edge sampling sees stable data mid-cycle.

## Interface
- IDLE_SLOTS, default 0: mandatory all-ones slots inserted after every transmitted frame (0..15).

- SYNCED_CLK  in  1  system clock; all state updates on rising edge.
- RST  in  1  reset, synchronous, active-low.
- REQ0  in  1  requester 0 has a byte pending; held high until granted.
- DATA0  in  8  requester 0 byte; stable while REQ0 high.
- GNT0  out  1  one-cycle grant pulse; DATA0 captured at the edge that raises it.
- REQ1  in  1  requester 1 pending.
- DATA1  in  8  requester 1 byte.
- GNT1  out  1  requester 1 grant pulse.
- SDATA  out  1  serial line, idle high.
- BUSY  out  1  high for all 11 cycles of a frame slot.
- OWNER  out  1  requester owning the current frame slot; valid while BUSY.
- SLOT_POS  out  4  current position in slot, 0..10.

## Operation
- Free-running slot counter SLOT_POS: 0,1,…,10,0,… No other values.
- Slot types: FRAME (carries a byte), IDLE (SDATA=1 all 11 cycles), HOLDOFF (as IDLE, counted against IDLE_SLOTS).
- Decision at the edge where SLOT_POS goes 10→0:
  - HOLDOFF count >0: next slot HOLDOFF, decrement, no grant.
  - Else, neither REQ: next slot IDLE.
  - Else, one REQ: grant it.
  - Else, both REQ: grant PRIO; PRIO then points to the other requester.
  - After any grant, PRIO points to the requester not granted. HOLDOFF count loads IDLE_SLOTS.
- Grant edge actions:
  - Pulse the granted GNTx.
  - Capture DATAx into the shift register.
  - Compute parity.
  - Set OWNER and BUSY.
  - Drive SDATA=0 (start bit).
- FRAME slot SDATA by position: 0 start=0; 1..8 data bit p-1; 9 parity; 10 stop=1.
- Parity is even by default: XOR of 8 data bits.
- A requester may change DATAx or drop REQx from the cycle after its GNTx onward. A REQx raised mid-slot waits for the next boundary.

## Timing
- Reset values:
  - SLOT_POS=0, SDATA=1, BUSY=0, OWNER=0.
  - GNT0=GNT1=0, PRIO=0 (requester 0 wins first tie), HOLDOFF count=0.
- The first slot after reset release is always IDLE. The earliest start bit is in the cycle where SLOT_POS first returns to 0, 11 cycles after the first non-reset edge.
- Latency from REQ sampled at the boundary to start bit on SDATA: 0 cycles, because the start bit is registered at the same edge as GNT.
- Back-to-back maximum throughput with IDLE_SLOTS=0: one frame per 11 cycles, with no gap between stop and the next start.
- GNTx is high only in SLOT_POS=0 cycles and never both at once.
- BUSY falls at the edge ending position 10 unless the next slot is also a FRAME.
- Reset mid-frame:
  - At the next edge the frame is abandoned and all state returns to reset values.
  - SDATA=1 from that edge onward.
  - No grant is reissued for the lost byte. The requester's REQ is still high and is re-arbitrated normally.

## Configuration
- PARITY_ODD_EN:
  - Defined: parity bit = inverted XOR of data (odd parity).
  - Undefined: even parity, as described above.

## Test plan
- Reset release, REQ0=1 DATA0=8'hA5 held -> first 11 cycles SDATA=1, BUSY=0. Next slot SDATA = 0,1,0,1,0,0,1,0,1,0,1 (even parity 0). GNT0 pulses at SLOT_POS=0.
- REQ0 and REQ1 both continuously high, DATA0=8'h01, DATA1=8'h02, IDLE_SLOTS=0 -> owners alternate 0,1,0,1 on consecutive slots with no idle slot between. Each GNT is a single-cycle pulse.
- IDLE_SLOTS=2, REQ1 held high -> FRAME, IDLE, IDLE, FRAME pattern; SLOT_POS spacing between GNT1 pulses = 33 cycles.
- REQ0 raised at SLOT_POS=5 of an idle slot -> no grant until the next SLOT_POS=0. The start bit appears in that cycle.
- RST low at SLOT_POS=4 of a FRAME -> next edge SDATA=1, SLOT_POS=0, BUSY=0. With REQ0 and REQ1 both held, the first frame after reset is granted to requester 0.
- PARITY_ODD_EN defined, DATA0=8'hFF -> parity bit 1; undefined -> parity bit 0.
